// File: rtl/frame_buffer.sv
// rtl/frame_buffer.sv - double-buffered RGB frame store feeding a HUB75 scan driver
module frame_buffer #(
  parameter int bit_depth  = 4,
  parameter int width      = 64,
  parameter int height     = 64,
  parameter int plane_bits = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          wr_en,
  input  logic [$clog2(width)-1:0]      wr_x,
  input  logic [$clog2(height)-1:0]     wr_y,
  input  logic [3*bit_depth-1:0]        wr_rgb,
  input  logic                          clear_req,
  input  logic                          swap_req,
  input  logic                          frame_sync,
  input  logic                          rd_en,
  input  logic [$clog2(height)-2:0]     rd_row,
  input  logic [$clog2(width)-1:0]      rd_col,
  input  logic [plane_bits-1:0]         rd_plane,
  output logic [5:0]                    col_bits,
  output logic                          rd_valid,
  output logic                          busy,
  output logic                          swap_pending,
  output logic                          swap_done,
  output logic                          front_bank
);

  localparam int COL_W  = $clog2(width);
  localparam int ROW_W  = $clog2(height) - 1;
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DEPTH  = 2 ** (ADDR_W + 1);
  localparam int WORD_W = 3 * bit_depth;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  // Each half memory holds both banks; the bank is the MSB of the address.
  logic [WORD_W-1:0]     r_mem_top [0:DEPTH-1];
  logic [WORD_W-1:0]     r_mem_bot [0:DEPTH-1];

  state_t                r_state;
  logic [ADDR_W-1:0]     r_clr_cnt;
  logic                  r_clr_bank;
  logic                  r_busy;

  logic                  r_front;
  logic                  r_swap_pending;
  logic                  r_swap_done;

  logic [WORD_W-1:0]     r_top_q;
  logic [WORD_W-1:0]     r_bot_q;
  logic                  r_rd_v1;
  logic [plane_bits-1:0] r_plane1;
  logic                  r_rd_valid;
  logic [5:0]            r_col_bits;

  logic                  w_clearing;
  logic                  w_pix_we;
  logic                  w_top_we;
  logic                  w_bot_we;
  logic [ADDR_W:0]       w_wr_addr;
  logic [WORD_W-1:0]     w_wr_data;
  logic [ADDR_W:0]       w_rd_addr;
  logic                  w_swap_fire;
  logic [bit_depth-1:0]  w_top_r, w_top_g, w_top_b;
  logic [bit_depth-1:0]  w_bot_r, w_bot_g, w_bot_b;

  // Pixel writes always land in the back bank; the clear engine owns both write ports while busy.
  assign w_clearing  = (r_state == S_CLEAR);
  assign w_pix_we    = wr_en & ~r_busy;
  assign w_top_we    = w_clearing | (w_pix_we & ~wr_y[ROW_W]);
  assign w_bot_we    = w_clearing | (w_pix_we &  wr_y[ROW_W]);
  assign w_wr_addr   = w_clearing ? {r_clr_bank, r_clr_cnt}
                                  : {~r_front, wr_y[ROW_W-1:0], wr_x};
  assign w_wr_data   = w_clearing ? '0 : wr_rgb;
  assign w_rd_addr   = {r_front, rd_row, rd_col};

  // A clear in progress blocks the swap so the bank being zeroed never becomes visible half-done.
  assign w_swap_fire = frame_sync & (r_swap_pending | swap_req) & ~r_busy;

  // Top-half memory (rows 0..height/2-1): shared write port, read port for the scan driver
  always_ff @(posedge CLK) begin
    if (w_top_we) r_mem_top[w_wr_addr] <= w_wr_data;
    if (rd_en)    r_top_q <= r_mem_top[w_rd_addr];
  end

  // Bottom-half memory (rows height/2..height-1): same structure as the top half
  always_ff @(posedge CLK) begin
    if (w_bot_we) r_mem_bot[w_wr_addr] <= w_wr_data;
    if (rd_en)    r_bot_q <= r_mem_bot[w_rd_addr];
  end

  // Clear FSM: walks every address of the back bank captured at request time, one per cycle
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      r_clr_bank <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state    <= S_CLEAR;
            r_clr_cnt  <= '0;
            r_clr_bank <= ~r_front;
            r_busy     <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == {ADDR_W{1'b1}}) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Swap control: requests are held until an end-of-frame pulse arrives outside a clear
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_front        <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
    end else begin
      r_swap_done <= w_swap_fire;
      if (w_swap_fire) begin
        r_front        <= ~r_front;
        r_swap_pending <= 1'b0;
      end else if (swap_req) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  // Read stage 1: track which memory reads are live and remember the requested plane
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rd_v1  <= 1'b0;
      r_plane1 <= '0;
    end else begin
      r_rd_v1 <= rd_en;
      if (rd_en) r_plane1 <= rd_plane;
    end
  end

  assign w_top_r = r_top_q[2*bit_depth +: bit_depth];
  assign w_top_g = r_top_q[bit_depth   +: bit_depth];
  assign w_top_b = r_top_q[0           +: bit_depth];
  assign w_bot_r = r_bot_q[2*bit_depth +: bit_depth];
  assign w_bot_g = r_bot_q[bit_depth   +: bit_depth];
  assign w_bot_b = r_bot_q[0           +: bit_depth];

  // Read stage 2: pick one bit plane from each channel of both halves and register the result
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rd_valid <= 1'b0;
      r_col_bits <= '0;
    end else begin
      r_rd_valid <= r_rd_v1;
      if (r_rd_v1) begin
        r_col_bits <= {w_bot_b[r_plane1], w_top_b[r_plane1],
                       w_bot_g[r_plane1], w_top_g[r_plane1],
                       w_bot_r[r_plane1], w_top_r[r_plane1]};
      end
    end
  end

  assign col_bits     = r_col_bits;
  assign rd_valid     = r_rd_valid;
  assign busy         = r_busy;
  assign swap_pending = r_swap_pending;
  assign swap_done    = r_swap_done;
  assign front_bank   = r_front;

endmodule

// File: tb/tb_frame_buffer.sv
// tb/tb_frame_buffer.sv - randomized self-checking bench for frame_buffer
module tb_frame_buffer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wr_en;
  logic [5:0]  wr_x;
  logic [5:0]  wr_y;
  logic [11:0] wr_rgb;
  logic        clear_req;
  logic        swap_req;
  logic        frame_sync;
  logic        rd_en;
  logic [4:0]  rd_row;
  logic [5:0]  rd_col;
  logic [1:0]  rd_plane;
  logic [5:0]  col_bits;
  logic        rd_valid;
  logic        busy;
  logic        swap_pending;
  logic        swap_done;
  logic        front_bank;

  always #5 CLK = ~CLK;

  frame_buffer dut (
    .CLK(CLK), .RST_N(RST_N),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .clear_req(clear_req), .swap_req(swap_req), .frame_sync(frame_sync),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_plane(rd_plane),
    .col_bits(col_bits), .rd_valid(rd_valid), .busy(busy),
    .swap_pending(swap_pending), .swap_done(swap_done), .front_bank(front_bank)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixel image per bank, indexed [bank][y][x]
  logic [11:0] m_mem [2][64][64];
  bit          m_front, m_pending, m_done, m_busy, m_clr_bank, m_rst_edge;
  int          m_clr_idx;
  bit          m_p1_valid, m_valid;
  logic [5:0]  m_p1_col, m_col;

  function automatic logic [5:0] model_bits(bit b, int row, int col, int p);
    logic [11:0] t, u;
    t = m_mem[b][row][col];
    u = m_mem[b][row + 32][col];
    return {u[p], t[p], u[4 + p], t[4 + p], u[8 + p], t[8 + p]};
  endfunction

  task automatic idle_pulses();
    wr_en = 0; clear_req = 0; swap_req = 0; frame_sync = 0; rd_en = 0;
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge
  task automatic tick();
    bit fire;
    if (!RST_N) begin
      m_front = 0; m_pending = 0; m_done = 0; m_busy = 0;
      m_p1_valid = 0; m_valid = 0; m_col = 0; m_rst_edge = 1;
    end else begin
      m_rst_edge = 0;
      m_valid = m_p1_valid;
      if (m_p1_valid) m_col = m_p1_col;
      m_p1_valid = rd_en;
      if (rd_en) m_p1_col = model_bits(m_front, rd_row, rd_col, rd_plane);
      fire = frame_sync && (m_pending || swap_req) && !m_busy;
      if (m_busy) begin
        m_mem[m_clr_bank][m_clr_idx / 64][m_clr_idx % 64] = 12'h000;
        m_mem[m_clr_bank][m_clr_idx / 64 + 32][m_clr_idx % 64] = 12'h000;
        m_clr_idx++;
        if (m_clr_idx == 2048) m_busy = 0;
      end else begin
        if (wr_en) m_mem[!m_front][wr_y][wr_x] = wr_rgb;
        if (clear_req) begin
          m_busy = 1; m_clr_bank = !m_front; m_clr_idx = 0;
        end
      end
      m_pending = fire ? 1'b0 : (m_pending || swap_req);
      m_done = fire;
      if (fire) m_front = !m_front;
    end
    @(posedge CLK);
    #1;
    check("rd_valid", rd_valid, m_valid);
    if (m_valid || m_rst_edge) check("col_bits", col_bits, m_col);
    check("busy", busy, m_busy);
    check("swap_pending", swap_pending, m_pending);
    check("swap_done", swap_done, m_done);
    check("front_bank", front_bank, m_front);
    idle_pulses();
  endtask

  task automatic wait_not_busy();
    int k = 0;
    while (busy && k < 3000) begin tick(); k++; end
    check("busy_timeout", busy, 0);
  endtask

  task automatic do_swap();
    swap_req = 1; frame_sync = 1; tick();
  endtask

  task automatic rand_read();
    rd_en = 1;
    rd_row = 5'($urandom_range(0, 31));
    rd_col = 6'($urandom_range(0, 63));
    rd_plane = 2'($urandom_range(0, 3));
  endtask

  task automatic rand_write();
    wr_en = 1;
    wr_x = 6'($urandom); wr_y = 6'($urandom); wr_rgb = 12'($urandom);
  endtask

  initial begin
    int cnt, dcnt;
    bit f0;
    RST_N = 0; idle_pulses();
    wr_x = 0; wr_y = 0; wr_rgb = 0; rd_row = 0; rd_col = 0; rd_plane = 0;
    tick(); tick();
    check("rst_front", front_bank, 0);
    check("rst_valid", rd_valid, 0);
    RST_N = 1;
    tick();

    // Bring both banks to a known all-zero image
    clear_req = 1; tick(); wait_not_busy();
    do_swap();
    clear_req = 1; tick(); wait_not_busy();
    do_swap();

    // Directed pixel pair, then read all four planes of that column
    wr_en = 1; wr_x = 5; wr_y = 3;  wr_rgb = 12'hA50; tick();
    wr_en = 1; wr_x = 5; wr_y = 35; wr_rgb = 12'h0F3; tick();
    do_swap();
    for (int p = 0; p < 4; p++) begin
      rd_en = 1; rd_row = 3; rd_col = 5; rd_plane = 2'(p); tick();
    end
    tick(); tick();

    // Swap request held across many cycles until the end-of-frame pulse
    swap_req = 1; tick();
    cnt = int'(swap_pending); dcnt = 0;
    for (int i = 0; i < 39; i++) begin
      tick(); cnt += int'(swap_pending); dcnt += int'(swap_done);
    end
    frame_sync = 1; tick(); cnt += int'(swap_pending); dcnt += int'(swap_done);
    tick(); dcnt += int'(swap_done);
    check("pend_len", cnt, 40);
    check("done_len", dcnt, 1);

    // End-of-frame with nothing pending leaves the bank alone
    f0 = m_front;
    frame_sync = 1; tick();
    check("fs_alone", front_bank, f0);

    // Random mixed traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1)) rand_write();
      if ($urandom_range(0, 1)) rand_read();
      swap_req   = ($urandom_range(0, 19) == 0);
      frame_sync = ($urandom_range(0, 24) == 0);
      tick();
    end
    tick(); tick();

    // Fill back bank, clear it while attempting writes and an early swap
    for (int i = 0; i < 200; i++) begin
      rand_write();
      if ($urandom_range(0, 1)) rand_read();
      tick();
    end
    clear_req = 1; tick();
    cnt = int'(busy);
    for (int k = 0; busy && k < 3000; k++) begin
      if ($urandom_range(0, 1)) rand_write();
      if (k == 100) swap_req = 1;
      if (k == 1000 || k == 2046) frame_sync = 1;
      if (k == 500) clear_req = 1;
      tick();
      cnt += int'(busy);
    end
    check("busy_len", cnt, 2048);
    check("pend_after_clear", swap_pending, 1);
    tick();
    frame_sync = 1; tick();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++)
        for (int p = 0; p < 4; p++) begin
          rd_en = 1; rd_row = 5'(r); rd_col = 6'(c); rd_plane = 2'(p);
          tick();
          if (rd_valid) check("clr_zero", col_bits, 0);
        end
    tick(); tick();

    // Reset during a clear with two reads in flight
    clear_req = 1; tick();
    for (int i = 0; i < 100; i++) tick();
    rand_read(); tick();
    rand_read(); tick();
    RST_N = 0; tick();
    check("rst2_valid", rd_valid, 0);
    check("rst2_bits", col_bits, 0);
    check("rst2_busy", busy, 0);
    check("rst2_front", front_bank, 0);
    RST_N = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_valid", rd_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
